// File: rtl/bus_window_pkg.sv
// Shared types, sizing helpers and the default MTL-1 memory map for the
// 6809 bus window controller.
package bus_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    // Default MTL-1 map: SRAM 0x0000, expansion 0x1000, I/O 0xA000, ROM 0xF000.
    localparam int unsigned MTL1_NUM_WIN  = 4;
    localparam logic [63:0] MTL1_WIN_BASE = {16'hF000, 16'hA000, 16'h1000, 16'h0000};
    localparam logic [63:0] MTL1_WIN_MASK = {16'hF000, 16'hE000, 16'hF000, 16'hF000};
    localparam logic [3:0]  MTL1_WIN_SLOW = 4'b1000;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_match.sv
// Combinational address-window compare with lowest-index priority encoding.
module window_match
    import bus_window_pkg::*;
#(
    parameter int unsigned                 NUM_WIN  = 4,
    parameter int unsigned                 ADDR_W   = 16,
    parameter logic [NUM_WIN*ADDR_W-1:0]   WIN_BASE = MTL1_WIN_BASE,
    parameter logic [NUM_WIN*ADDR_W-1:0]   WIN_MASK = MTL1_WIN_MASK,
    localparam int unsigned                IDX_W    = idx_width(NUM_WIN)
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic               hit,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_WIN-1:0] onehot
);

    logic [NUM_WIN-1:0] raw_hit;

    always_comb begin
        raw_hit = '0;
        for (int unsigned i = 0; i < NUM_WIN; i++) begin
            raw_hit[i] = ((addr & WIN_MASK[i*ADDR_W +: ADDR_W]) == WIN_BASE[i*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int unsigned i = 0; i < NUM_WIN; i++) begin
            if (raw_hit[i] && !hit) begin
                hit       = 1'b1;
                idx       = IDX_W'(i);
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_window_controller.sv
// 6809 bus-cycle engine: decodes programmable address windows, strobes the
// selected channel and stretches the CPU cycle via MRDY for slow windows.
module bus_window_controller
    import bus_window_pkg::*;
#(
    parameter int unsigned               NUM_WIN  = 4,
    parameter int unsigned               ADDR_W   = 16,
    parameter int unsigned               DATA_W   = 8,
    parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE = MTL1_WIN_BASE,
    parameter logic [NUM_WIN*ADDR_W-1:0] WIN_MASK = MTL1_WIN_MASK,
    parameter logic [NUM_WIN-1:0]        WIN_SLOW = MTL1_WIN_SLOW,
    parameter int unsigned               TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_E,
    input  logic                      i_RW,
    input  logic [ADDR_W-1:0]         i_ADDRESS_BUS,
    input  logic [DATA_W-1:0]         i_DATA_BUS,
    output logic [DATA_W-1:0]         o_DATA_BUS,
    output logic                      o_DATA_OE,
    output logic                      o_MRDY,
    output logic [NUM_WIN-1:0]        o_ce,
    output logic [NUM_WIN-1:0]        o_rd_strobe,
    output logic [NUM_WIN-1:0]        o_wr_strobe,
    output logic [DATA_W-1:0]         o_wdata,
    input  logic [NUM_WIN*DATA_W-1:0] i_rdata,
    input  logic [NUM_WIN-1:0]        i_ready,
    output logic                      o_timeout,
    input  logic                      i_clear_timeout
);

    localparam int unsigned      IDX_W     = idx_width(NUM_WIN);
    localparam int unsigned      CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    // Synchroniser chains: [0] first stage, [1] synced value, e_sh[2] edge delay.
    logic [2:0]        e_sh_q, e_sh_d;
    logic [1:0]        rw_sh_q, rw_sh_d;
    logic [ADDR_W-1:0] addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;
    logic [DATA_W-1:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ch_q, ch_d;
    logic [NUM_WIN-1:0]   ce_q, ce_d;
    logic                 rw_q, rw_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mrdy_q, mrdy_d;
    logic                 oe_q, oe_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 fast_pend_q, fast_pend_d;
    logic [NUM_WIN-1:0]   rd_strobe_q, rd_strobe_d;
    logic [NUM_WIN-1:0]   wr_strobe_q, wr_strobe_d;
    logic [DATA_W-1:0]    wshadow_q, wshadow_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 timeout_q, timeout_d;

    logic                 e_rise, e_fall;
    logic                 timeout_set;
    logic                 win_hit;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_WIN-1:0]   win_onehot;
    logic [DATA_W-1:0]    rdata_slice;

    window_match #(
        .NUM_WIN  (NUM_WIN),
        .ADDR_W   (ADDR_W),
        .WIN_BASE (WIN_BASE),
        .WIN_MASK (WIN_MASK)
    ) u_match (
        .addr   (addr_s2_q),
        .hit    (win_hit),
        .idx    (win_idx),
        .onehot (win_onehot)
    );

    always_comb begin
        e_sh_d    = {e_sh_q[1:0], i_E};
        rw_sh_d   = {rw_sh_q[0], i_RW};
        addr_s1_d = i_ADDRESS_BUS;
        addr_s2_d = addr_s1_q;
        data_s1_d = i_DATA_BUS;
        data_s2_d = data_s1_q;
    end

    assign e_rise      = e_sh_q[1] & ~e_sh_q[2];
    assign e_fall      = ~e_sh_q[1] & e_sh_q[2];
    assign rdata_slice = i_rdata[ch_q*DATA_W +: DATA_W];

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ce_d        = ce_q;
        rw_d        = rw_q;
        cnt_d       = cnt_q;
        mrdy_d      = mrdy_q;
        oe_d        = oe_q;
        rdata_d     = rdata_q;
        fast_pend_d = 1'b0;
        rd_strobe_d = '0;
        wr_strobe_d = '0;
        wshadow_d   = wshadow_q;
        wdata_d     = wdata_q;
        timeout_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (e_rise && win_hit) begin
                    state_d = ST_DECODE;
                    ch_d    = win_idx;
                    ce_d    = win_onehot;
                    rw_d    = rw_sh_q[1];
                end
            end

            ST_DECODE: begin
                if (rw_q) begin
                    rd_strobe_d = ce_q;
                    if (WIN_SLOW[ch_q]) begin
                        state_d = ST_WAIT;
                        mrdy_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d     = ST_HOLD;
                        fast_pend_d = 1'b1;
                    end
                end else begin
                    state_d   = ST_HOLD;
                    wshadow_d = data_s2_q;
                end
            end

            ST_WAIT: begin
                // cnt_d counts completed WAIT clocks, so MRDY stays low for at most TIMEOUT clocks.
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (e_fall) begin
                    state_d = ST_IDLE;
                    mrdy_d  = 1'b1;
                    ce_d    = '0;
                end else if (i_ready[ch_q]) begin
                    state_d = ST_HOLD;
                    mrdy_d  = 1'b1;
                    oe_d    = 1'b1;
                    rdata_d = rdata_slice;
                end else if (cnt_d == CNT_LIMIT) begin
                    state_d     = ST_HOLD;
                    mrdy_d      = 1'b1;
                    oe_d        = 1'b1;
                    rdata_d     = '1;
                    timeout_set = 1'b1;
                end
            end

            ST_HOLD: begin
                if (fast_pend_q) begin
                    rdata_d = rdata_slice;
                    oe_d    = 1'b1;
                end
                if (e_fall) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    ce_d    = '0;
                    if (!rw_q) begin
                        wr_strobe_d = ce_q;
                        wdata_d     = wshadow_q;
                    end
                end else if (!rw_q) begin
                    wshadow_d = data_s2_q;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        timeout_d = timeout_set ? 1'b1 : (i_clear_timeout ? 1'b0 : timeout_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_sh_q      <= '0;
            rw_sh_q     <= '0;
            addr_s1_q   <= '0;
            addr_s2_q   <= '0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            ce_q        <= '0;
            rw_q        <= 1'b0;
            cnt_q       <= '0;
            mrdy_q      <= 1'b1;
            oe_q        <= 1'b0;
            rdata_q     <= '0;
            fast_pend_q <= 1'b0;
            rd_strobe_q <= '0;
            wr_strobe_q <= '0;
            wshadow_q   <= '0;
            wdata_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            e_sh_q      <= e_sh_d;
            rw_sh_q     <= rw_sh_d;
            addr_s1_q   <= addr_s1_d;
            addr_s2_q   <= addr_s2_d;
            data_s1_q   <= data_s1_d;
            data_s2_q   <= data_s2_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            ce_q        <= ce_d;
            rw_q        <= rw_d;
            cnt_q       <= cnt_d;
            mrdy_q      <= mrdy_d;
            oe_q        <= oe_d;
            rdata_q     <= rdata_d;
            fast_pend_q <= fast_pend_d;
            rd_strobe_q <= rd_strobe_d;
            wr_strobe_q <= wr_strobe_d;
            wshadow_q   <= wshadow_d;
            wdata_q     <= wdata_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_DATA_BUS  = rdata_q;
    assign o_DATA_OE   = oe_q;
    assign o_MRDY      = mrdy_q;
    assign o_ce        = ce_q;
    assign o_rd_strobe = rd_strobe_q;
    assign o_wr_strobe = wr_strobe_q;
    assign o_wdata     = wdata_q;
    assign o_timeout   = timeout_q;

endmodule
